m_div_ctrl: RTL and testbench

M_DIV_CTRL -- requirements
Module: m_div_ctrl

---
 rtl/m_div_ctrl_pkg.sv | 41 ++++
 rtl/m_div_ctrl_if.sv | 31 +++
 rtl/m_div_ctrl.sv | 89 ++++++++
 tb/tb_m_div_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/m_div_ctrl_pkg.sv
// Shared encodings for the iterative divider controller: mux selects, op codes, FSM states.
package m_div_ctrl_pkg;

   localparam int MUX_R_LENGTH = 2;
   localparam int MUX_D_LENGTH = 2;
   localparam int MUX_Z_LENGTH = 2;

   localparam logic [MUX_R_LENGTH-1:0] MUX_R_KEEP     = 2'd0;
   localparam logic [MUX_R_LENGTH-1:0] MUX_R_A        = 2'd1;
   localparam logic [MUX_R_LENGTH-1:0] MUX_R_A_NEG    = 2'd2;
   localparam logic [MUX_R_LENGTH-1:0] MUX_R_SUB_KEEP = 2'd3;

   localparam logic [MUX_D_LENGTH-1:0] MUX_D_KEEP  = 2'd0;
   localparam logic [MUX_D_LENGTH-1:0] MUX_D_B     = 2'd1;
   localparam logic [MUX_D_LENGTH-1:0] MUX_D_B_NEG = 2'd2;
   localparam logic [MUX_D_LENGTH-1:0] MUX_D_SHR   = 2'd3;

   localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_KEEP    = 2'd0;
   localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_ZERO    = 2'd1;
   localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_SHL_ADD = 2'd2;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // funct3[0] clear means signed (DIV, REM); funct3[1] set selects remainder
   function automatic logic op_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return 32'(~v + 32'd1);
   endfunction

endpackage

// File: rtl/m_div_ctrl_if.sv
// Controller <-> requester/datapath bundle; slave is the controller side.
interface m_div_ctrl_if;
   import m_div_ctrl_pkg::*;

   logic                    start;
   logic [1:0]              op;
   logic [31:0]             rs1;
   logic [31:0]             rs2;
   logic                    sub_neg;
   logic [31:0]             R;
   logic [31:0]             Z;
   logic [31:0]             rs1_neg;
   logic [31:0]             rs2_neg;
   logic [MUX_R_LENGTH-1:0] mux_R;
   logic [MUX_D_LENGTH-1:0] mux_D;
   logic [MUX_Z_LENGTH-1:0] mux_Z;
   logic                    busy;
   logic                    done;
   logic [31:0]             result;

   modport master (
      output start, op, rs1, rs2, sub_neg, R, Z,
      input  rs1_neg, rs2_neg, mux_R, mux_D, mux_Z, busy, done, result
   );

   modport slave (
      input  start, op, rs1, rs2, sub_neg, R, Z,
      output rs1_neg, rs2_neg, mux_R, mux_D, mux_Z, busy, done, result
   );

endinterface

// File: rtl/m_div_ctrl.sv
// Sequencing FSM for a 32-step restoring divider; the shift/subtract datapath lives in m_registers.
module m_div_ctrl
   import m_div_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         resetn,
   m_div_ctrl_if.slave  bus
);

   logic [1:0]  state;
   logic [4:0]  count;
   logic [1:0]  op_q;
   logic        q_neg;
   logic        r_neg;
   logic [31:0] result_q;

   logic sgn, div0, a_neg, b_neg;

   assign sgn   = op_signed(bus.op);
   assign div0  = (bus.rs2 == 32'd0);
   assign a_neg = sgn & bus.rs1[31];
   assign b_neg = sgn & bus.rs2[31];

   assign bus.rs1_neg = neg32(bus.rs1);
   assign bus.rs2_neg = neg32(bus.rs2);
   assign bus.busy    = (state != S_IDLE);
   assign bus.done    = (state == S_DONE);
   assign bus.result  = result_q;

   // Muxes are gated by resetn so the datapath holds while reset is asserted
   always_comb begin
      bus.mux_R = MUX_R_KEEP;
      bus.mux_D = MUX_D_KEEP;
      bus.mux_Z = MUX_Z_KEEP;
      if (resetn) begin
         case (state)
            S_IDLE: if (bus.start) begin
               bus.mux_R = a_neg ? MUX_R_A_NEG : MUX_R_A;
               bus.mux_D = b_neg ? MUX_D_B_NEG : MUX_D_B;
               bus.mux_Z = MUX_Z_ZERO;
            end
            S_ITER: begin
               bus.mux_R = MUX_R_SUB_KEEP;
               bus.mux_D = MUX_D_SHR;
               bus.mux_Z = MUX_Z_SHL_ADD;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         count    <= 5'd0;
         op_q     <= 2'b00;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         result_q <= 32'd0;
      end else begin
         case (state)
            S_IDLE: if (bus.start) begin
               op_q  <= bus.op;
               q_neg <= sgn & (bus.rs1[31] ^ bus.rs2[31]);
               r_neg <= a_neg;
               count <= 5'd0;
               // Divide by zero resolves immediately with the RISC-V defined values
               if (div0) begin
                  result_q <= bus.op[1] ? bus.rs1 : 32'hFFFF_FFFF;
                  state    <= S_DONE;
               end else begin
                  state    <= S_ITER;
               end
            end
            S_ITER: begin
               if (count == 5'd31) state <= S_FIX;
               else                count <= count + 5'd1;
            end
            S_FIX: begin
               if (op_q[1]) result_q <= r_neg ? neg32(bus.R) : bus.R;
               else         result_q <= q_neg ? neg32(bus.Z) : bus.Z;
               state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m_div_ctrl.sv
// Bench for m_div_ctrl: local restoring-divide datapath plus an arithmetic reference model.
module tb_m_div_ctrl;
   import m_div_ctrl_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   m_div_ctrl_if bus();

   m_div_ctrl dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Datapath: R holds |dividend| and is conditionally reduced, D is |divisor|<<31 shifted right each step
   logic [31:0] dp_r, dp_z;
   logic [62:0] dp_d;
   logic [63:0] diff;
   logic        sub_neg;
   assign diff        = {32'd0, dp_r} - {1'b0, dp_d};
   assign sub_neg     = diff[63];
   assign bus.sub_neg = sub_neg;
   assign bus.R       = dp_r;
   assign bus.Z       = dp_z;

   always @(posedge clk) begin
      case (bus.mux_R)
         MUX_R_A:        dp_r <= bus.rs1;
         MUX_R_A_NEG:    dp_r <= bus.rs1_neg;
         MUX_R_SUB_KEEP: if (!sub_neg) dp_r <= diff[31:0];
         default: ;
      endcase
      case (bus.mux_D)
         MUX_D_B:     dp_d <= {bus.rs2, 31'd0};
         MUX_D_B_NEG: dp_d <= {bus.rs2_neg, 31'd0};
         MUX_D_SHR:   dp_d <= dp_d >> 1;
         default: ;
      endcase
      case (bus.mux_Z)
         MUX_Z_ZERO:    dp_z <= 32'd0;
         MUX_Z_SHL_ADD: dp_z <= {dp_z[30:0], ~sub_neg};
         default: ;
      endcase
   end

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0]) begin
         sa = $signed(a);
         sb = $signed(b);
         return op[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      ua = {32'd0, a};
      ub = {32'd0, b};
      return op[1] ? 32'(ua % ub) : 32'(ua / ub);
   endfunction

   // Timing model: cycles of busy left after an accept (34 normal, 1 for divide by zero)
   int          m_cnt;
   logic        m_div0;
   logic [31:0] m_res, m_pend;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_cnt  <= 0;
         m_div0 <= 1'b0;
         m_res  <= 32'd0;
         m_pend <= 32'd0;
      end else if (m_cnt == 0) begin
         if (bus.start) begin
            m_div0 <= (bus.rs2 == 32'd0);
            m_pend <= ref_div(bus.op, bus.rs1, bus.rs2);
            if (bus.rs2 == 32'd0) begin
               m_cnt <= 1;
               m_res <= ref_div(bus.op, bus.rs1, bus.rs2);
            end else begin
               m_cnt <= 34;
            end
         end
      end else begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 2) m_res <= m_pend;
      end
   end

   always @(negedge clk) begin
      check("busy", 32'(bus.busy), 32'(m_cnt > 0));
      check("done", 32'(bus.done), 32'(m_cnt == 1));
      check("result", bus.result, m_res);
      if (!resetn || (m_cnt == 0 && !bus.start) || m_cnt == 1 || m_cnt == 2) begin
         check("mux_r_keep", 32'(bus.mux_R), 32'(MUX_R_KEEP));
         check("mux_d_keep", 32'(bus.mux_D), 32'(MUX_D_KEEP));
         check("mux_z_keep", 32'(bus.mux_Z), 32'(MUX_Z_KEEP));
      end else if (m_cnt >= 3 && !m_div0) begin
         check("mux_r_iter", 32'(bus.mux_R), 32'(MUX_R_SUB_KEEP));
         check("mux_d_iter", 32'(bus.mux_D), 32'(MUX_D_SHR));
         check("mux_z_iter", 32'(bus.mux_Z), 32'(MUX_Z_SHL_ADD));
      end
   end

   task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.rs1   = a;
      bus.rs2   = b;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && bus.busy; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // lat = posedges after the accept edge until done is seen (33 normal, 0 for divide by zero)
   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      check({name, "_model"}, ref_div(op, a, b), exp);
      wait_idle();
      drive(op, a, b);
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(lat);
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_res"}, bus.result, exp);
   endtask

   initial begin
      int lat;
      resetn    = 1'b0;
      bus.start = 1'b1;
      bus.op    = OP_DIV;
      bus.rs1   = 32'h8000_0000;
      bus.rs2   = 32'd0;
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_mux_r", 32'(bus.mux_R), 32'(MUX_R_KEEP));
      check("neg_min", bus.rs1_neg, 32'h8000_0000);
      check("neg_zero", bus.rs2_neg, 32'd0);
      bus.start = 1'b0;
      bus.rs1   = 32'd1;
      #1;
      check("neg_one", bus.rs1_neg, 32'hFFFF_FFFF);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      run("div_100_7",   OP_DIV,  32'd100,       32'd7, 32'd14,        33);
      run("rem_m100_7",  OP_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
      run("div_m100_7",  OP_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
      run("divu_max_2",  OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33);
      run("remu_max_2",  OP_REMU, 32'hFFFF_FFFF, 32'd2, 32'd1,         33);
      run("div_5_0",     OP_DIV,  32'd5,         32'd0, 32'hFFFF_FFFF, 0);
      run("rem_5_0",     OP_REM,  32'd5,         32'd0, 32'd5,         0);
      run("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
      run("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);
      run("div_m7_m2",   OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         33);
      run("rem_m7_m2",   OP_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33);
      run("divu_7_9",    OP_DIVU, 32'd7,         32'd9, 32'd0,         33);
      run("remu_7_9",    OP_REMU, 32'd7,         32'd9, 32'd7,         33);

      // Start while busy (ITER count 10) must be ignored
      wait_idle();
      drive(OP_DIV, 32'd100, 32'd7);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1 drive(OP_REM, 32'd5, 32'd0);
      check("ign_busy", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(lat);
      check("ign_lat", 32'(lat + 11), 32'd33);
      check("ign_res", bus.result, 32'd14);
      run("b2b_div", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33);

      // Reset at ITER count 16 abandons the operation
      wait_idle();
      drive(OP_DIV, 32'h1234_5678, 32'd3);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (16) @(posedge clk);
      #1 resetn = 1'b0;
      bus.start = 1'b1;
      #1;
      check("rstmid_busy", 32'(bus.busy), 32'd0);
      check("rstmid_done", 32'(bus.done), 32'd0);
      check("rstmid_res", bus.result, 32'd0);
      check("rstmid_mux_d", 32'(bus.mux_D), 32'(MUX_D_KEEP));
      repeat (2) @(posedge clk);
      #1;
      bus.start = 1'b0;
      resetn    = 1'b1;
      run("div_9_3", OP_DIV, 32'd9, 32'd3, 32'd3, 33);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
